// File: rtl/video_timing_pkg.sv
// video_timing_pkg: video timing constants shared with the timing generator, plus lock-state codes
// Used by video_sync_decoder; HSYNC_CLOCKS/VSYNC_LINES describe the generator side of the interface.
package video_timing_pkg;
    localparam int LINE_CLOCKS      = 2033;
    localparam int FRAME_LINES      = 263;
    localparam int HSYNC_CLOCKS     = 150;
    localparam int VSYNC_LINES      = 3;
    localparam int LINE_TOL         = 2;
    localparam int LOCK_LINES       = 4;
    localparam int ACTIVE_START     = 300;
    localparam int CLOCKS_PER_PIXEL = 6;
    localparam int ACTIVE_PIXELS    = 256;
    localparam int FIRST_LINE       = 20;
    localparam int ACTIVE_LINES     = 240;
    typedef logic [1:0] lock_state_t;
    localparam lock_state_t SEARCH = 2'd0;
    localparam lock_state_t VERIFY = 2'd1;
    localparam lock_state_t LOCKED = 2'd2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a sync input and flags its rise relative to a reference sample
// Ports: clock, reset_n (async, active-low), en (update reference), d (raw sync), rise (r & ~ref)
// With en tied high the reference is the previous cycle's value (plain edge detect); with en driven
// by another strobe the reference is the value held at that strobe.
module sync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic d,
    output logic rise
);
    logic r, p;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r <= 1'b0;
            p <= 1'b0;
        end else begin
            r <= d;
            if (en) p <= r;
        end
    end
    assign rise = r & ~p;
endmodule

// File: rtl/video_sync_decoder.sv
// video_sync_decoder: recovers line/frame timing from hsync/vsync and delivers sampled pixels
// Inputs: clock, reset_n (async, active-low), hsync_in, vsync_in, lum_in
// Outputs: line_clock[10:0], line_count[8:0], pixel_valid, pixel_lum, pixel_x[7:0], pixel_y[7:0],
//          frame_start, locked, sync_error
module video_sync_decoder
    import video_timing_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        lum_in,
    output logic [10:0] line_clock,
    output logic [8:0]  line_count,
    output logic        pixel_valid,
    output logic        pixel_lum,
    output logic [7:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error
);
    localparam logic [10:0] LC_LAST     = 11'(LINE_CLOCKS - 1);
    localparam logic [8:0]  LN_LAST     = 9'(FRAME_LINES - 1);
    localparam logic [11:0] LEN_MIN     = 12'(LINE_CLOCKS - LINE_TOL);
    localparam logic [11:0] LEN_MAX     = 12'(LINE_CLOCKS + LINE_TOL);
    // one below the timeout point so the pulse appears as the count reaches LINE_CLOCKS-1+LINE_TOL
    localparam logic [11:0] TIMEOUT_PRE = 12'(LINE_CLOCKS - 2 + LINE_TOL);
    localparam logic [10:0] ACT_START   = 11'(ACTIVE_START);
    localparam logic [2:0]  PH_LAST     = 3'(CLOCKS_PER_PIXEL - 1);
    localparam logic [2:0]  PH_SAMPLE   = 3'(CLOCKS_PER_PIXEL / 2);
    localparam logic [7:0]  K_LAST      = 8'(ACTIVE_PIXELS - 1);
    localparam logic [8:0]  Y_FIRST     = 9'(FIRST_LINE);
    localparam logic [8:0]  Y_END       = 9'(FIRST_LINE + ACTIVE_LINES);
    localparam logic [2:0]  GOOD_LAST   = 3'(LOCK_LINES - 1);
    logic        hs_edge, vs_rise, vs_new, lum_r;
    logic        good, armed, bad_edge, timeout, wrap, sample, hact;
    lock_state_t state;
    logic [2:0]  good_cnt, phase;
    logic [7:0]  px_k;
    logic [11:0] since_edge, measured;
    logic [10:0] lc_next;
    sync_edge_detect u_hsync (.clock(clock), .reset_n(reset_n), .en(1'b1), .d(hsync_in), .rise(hs_edge));
    // reference is vsync as seen at the previous hsync edge, so only the first vsync line restarts the frame
    sync_edge_detect u_vsync (.clock(clock), .reset_n(reset_n), .en(hs_edge), .d(vsync_in), .rise(vs_rise));
    assign vs_new   = hs_edge & vs_rise;
    assign measured = 12'(line_clock) + 12'd1;
    assign good     = measured >= LEN_MIN && measured <= LEN_MAX;
    assign armed    = state != SEARCH;
    assign bad_edge = armed & hs_edge & ~good;
    // since_edge saturates, so the timeout can fire only once per missing edge
    assign timeout  = armed & ~hs_edge & (since_edge == TIMEOUT_PRE);
    assign wrap     = line_clock == LC_LAST;
    assign lc_next  = (hs_edge | wrap) ? 11'd0 : line_clock + 11'd1;
    assign locked   = state == LOCKED;
    assign sample   = locked & hact & (phase == PH_SAMPLE) & (line_count >= Y_FIRST) & (line_count < Y_END);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lum_r       <= 1'b0;
            line_clock  <= '0;
            line_count  <= '0;
            since_edge  <= '0;
            state       <= SEARCH;
            good_cnt    <= '0;
            hact        <= 1'b0;
            phase       <= '0;
            px_k        <= '0;
            pixel_valid <= 1'b0;
            pixel_lum   <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            lum_r       <= lum_in;
            line_clock  <= lc_next;
            since_edge  <= hs_edge ? 12'd0 : (&since_edge ? since_edge : since_edge + 12'd1);
            line_count  <= vs_new ? 9'd0 : (hs_edge | wrap) ? (line_count == LN_LAST ? 9'd0 : line_count + 9'd1) : line_count;
            frame_start <= vs_new;
            sync_error  <= bad_edge | timeout;
            state       <= (bad_edge | timeout) ? VERIFY : !hs_edge ? state : (state == SEARCH) ? VERIFY :
                           (state == VERIFY && good_cnt == GOOD_LAST) ? LOCKED : state;
            good_cnt    <= (bad_edge | timeout | state != VERIFY) ? 3'd0 : hs_edge ? good_cnt + 3'd1 : good_cnt;
            hact        <= (lc_next == 11'd0) ? 1'b0 : (lc_next == ACT_START) ? 1'b1 : hact & ~(phase == PH_LAST && px_k == K_LAST);
            phase       <= (lc_next == ACT_START || phase == PH_LAST) ? 3'd0 : phase + 3'd1;
            px_k        <= (lc_next == ACT_START) ? 8'd0 : (hact && phase == PH_LAST) ? px_k + 8'd1 : px_k;
            pixel_valid <= sample;
            if (sample) begin
                pixel_lum <= lum_r;
                pixel_x   <= px_k;
                pixel_y   <= 8'(line_count - Y_FIRST);
            end
        end
    end
endmodule
